// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter for N request ports in front of one on-chip word memory,
// with byte/half/word write masking, alignment/range checking and a per-port error flag.
module mem_arbiter_rr #(
    parameter int BITSIZE     = 32,
    parameter int MEM_SIZE    = 1024,
    parameter int N_ACCESSORS = 2,
    parameter int LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           reset_i,
    input  logic [32*N_ACCESSORS-1:0]      acc_address_i,
    input  logic [N_ACCESSORS-1:0]         acc_write_i,
    input  logic [2*N_ACCESSORS-1:0]       acc_write_size_i,
    input  logic [N_ACCESSORS-1:0]         acc_read_i,
    input  logic [N_ACCESSORS*BITSIZE-1:0] acc_data_i,
    output logic [N_ACCESSORS*BITSIZE-1:0] acc_data_o,
    output logic [N_ACCESSORS-1:0]         acc_done_o,
    output logic [N_ACCESSORS-1:0]         acc_err_o
);
    localparam int PW = N_ACCESSORS > 1 ? $clog2(N_ACCESSORS) : 1;
    localparam int AW = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;

    logic [1:0]             state;
    logic [PW-1:0]          ptr, g, nxt;
    logic [CW-1:0]          cnt;
    logic [31:0]            addr_q;
    logic [BITSIZE-1:0]     data_q;
    logic [1:0]             size_q;
    logic                   wr_q, err_q, bad, commit;
    logic [N_ACCESSORS-1:0] req, rot;
    logic [3:0]             lanes;
    logic [AW-1:0]          idx;
    logic [BITSIZE-1:0]     mem [MEM_SIZE];

    assign req = acc_read_i | acc_write_i;
    // Rotate requests so bit 0 is the port at ptr; the lowest set bit is the winner.
    assign rot = N_ACCESSORS'({req, req} >> ptr);

    always_comb begin
        nxt = ptr;
        for (int i = N_ACCESSORS - 1; i >= 0; i--)
            if (rot[i]) nxt = PW'((int'(ptr) + i) % N_ACCESSORS);
    end

    assign idx    = addr_q[AW+1:2];
    assign bad    = ({2'b00, addr_q[31:2]} >= 32'(MEM_SIZE)) ||
                    (wr_q && (size_q == 2'd3 ||
                              (size_q == 2'd1 && addr_q[0]) ||
                              (size_q == 2'd2 && addr_q[1:0] != 2'd0)));
    assign lanes  = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                    size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign commit = state == ACCESS && cnt == CW'(LATENCY - 1) && !reset_i;
    // Reset held during RESP swallows the pending done pulse.
    assign acc_done_o = (state == RESP && !reset_i) ? N_ACCESSORS'(1) << g : '0;
    assign acc_err_o  = acc_done_o & {N_ACCESSORS{err_q}};

    always_ff @(posedge clk)
        if (commit && wr_q && !bad)
            for (int l = 0; l < 4; l++)
                if (lanes[l]) mem[idx][8*l +: 8] <= data_q[8*l +: 8];

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state      <= IDLE;
            ptr        <= '0;
            g          <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            acc_data_o <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    g      <= nxt;
                    addr_q <= acc_address_i[32*nxt +: 32];
                    data_q <= acc_data_i[BITSIZE*nxt +: BITSIZE];
                    size_q <= acc_write_size_i[2*nxt +: 2];
                    wr_q   <= acc_write_i[nxt];
                    cnt    <= '0;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (commit) begin
                        err_q <= bad;
                        if (!wr_q && !bad) acc_data_o[BITSIZE*g +: BITSIZE] <= mem[idx];
                        state <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= (g == PW'(N_ACCESSORS - 1)) ? '0 : g + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
